// File: rtl/dp_lane_scrambler.sv
// Per-lane DisplayPort scrambler: scrambles data symbols with the x^16+x^5+x^4+x^3+1 LFSR and passes K-codes through.
// Latency: exactly 1 clock from iso_* inputs to scr_* outputs; all outputs are registered.
// Backpressure: none; one symbol is accepted every clock while lane_en=1, and the stream cannot be stalled.
module dp_lane_scrambler #(
  parameter logic [15:0]  LFSR_SEED    = 16'hFFFF,
  parameter logic [7:0]   SR_CODE      = 8'h1C,
  parameter logic [255:0] K_LEGAL_MASK = (256'd1 << 8'h1C) | (256'd1 << 8'h3C) |
                                         (256'd1 << 8'h5C) | (256'd1 << 8'h7C) |
                                         (256'd1 << 8'h9C) | (256'd1 << 8'hBC) |
                                         (256'd1 << 8'hDC) | (256'd1 << 8'hFC) |
                                         (256'd1 << 8'hF7) | (256'd1 << 8'hFB) |
                                         (256'd1 << 8'hFD) | (256'd1 << 8'hFE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lane_en,
  input  logic       scramble_bypass,
  input  logic [7:0] iso_symbols,
  input  logic       iso_control_sym_flag,
  output logic [7:0] scr_symbols,
  output logic       scr_control_sym_flag,
  output logic       scr_vld,
  output logic       illegal_k,
  output logic       sr_seen
);

  // Lane operating mode. This is decoded directly from the inputs every
  // cycle; there is no handshake or stored mode state.
  typedef enum logic [1:0] {
    MODE_DISABLED = 2'd0,
    MODE_BYPASS   = 2'd1,
    MODE_ACTIVE   = 2'd2
  } mode_e;

  // Advance the Galois LFSR by eight single-bit steps. The low byte of the
  // result is the key, with bit k being the feedback bit of step k. The upper
  // 16 bits are the LFSR state after all eight steps.
  function automatic logic [23:0] lfsr_step8(input logic [15:0] state);
    logic [15:0] st;
    logic [7:0]  key;
    logic        fb;
    st  = state;
    key = 8'h00;
    for (int k = 0; k < 8; k++) begin
      fb     = st[15];
      key[k] = fb;
      st     = {st[14:0], fb} ^ {10'b0, {3{fb}}, 3'b0};
    end
    return {st, key};
  endfunction

  logic [15:0] r_lfsr;
  logic [7:0]  r_scr_symbols;
  logic        r_scr_control_sym_flag;
  logic        r_scr_vld;
  logic        r_illegal_k;
  logic        r_sr_seen;

  mode_e       w_mode;
  logic [23:0] w_step;
  logic [15:0] w_lfsr_adv;
  logic [7:0]  w_key;
  logic        w_is_legal_k;
  logic        w_is_sr;
  logic [15:0] w_lfsr_nxt;
  logic [7:0]  w_sym_nxt;
  logic        w_flag_nxt;
  logic        w_vld_nxt;
  logic        w_ill_nxt;
  logic        w_sr_nxt;

  assign w_step       = lfsr_step8(r_lfsr);
  assign w_lfsr_adv   = w_step[23:8];
  assign w_key        = w_step[7:0];
  assign w_is_legal_k = K_LEGAL_MASK[iso_symbols];
  assign w_is_sr      = iso_control_sym_flag && (iso_symbols == SR_CODE);

  // Decode the mode. A disabled lane outranks bypass.
  always_comb begin
    w_mode = MODE_ACTIVE;
    if (!lane_en) begin
      w_mode = MODE_DISABLED;
    end else if (scramble_bypass) begin
      w_mode = MODE_BYPASS;
    end
  end

  // Next output symbol and LFSR state for the current input symbol.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    w_sym_nxt  = 8'h00;
    w_flag_nxt = 1'b0;
    w_vld_nxt  = 1'b0;
    w_ill_nxt  = 1'b0;
    w_sr_nxt   = 1'b0;
    case (w_mode)
      MODE_DISABLED: begin
        // Idle lane: outputs are quiet and the LFSR is parked on the seed, so
        // the first data symbol after re-enable is scrambled from the seed.
        w_lfsr_nxt = LFSR_SEED;
      end
      MODE_BYPASS: begin
        // Training patterns are sent in the clear. SR does not act as a
        // scrambler reset here, because the LFSR is already held on the seed.
        // Illegal K-codes are still flagged.
        w_lfsr_nxt = LFSR_SEED;
        w_vld_nxt  = 1'b1;
        w_sym_nxt  = iso_symbols;
        w_flag_nxt = iso_control_sym_flag;
        w_ill_nxt  = iso_control_sym_flag && !w_is_legal_k;
      end
      default: begin
        w_vld_nxt  = 1'b1;
        w_flag_nxt = iso_control_sym_flag;
        if (w_is_sr) begin
          // Re-seed without advancing, so the next symbol uses the seed key.
          w_sym_nxt  = iso_symbols;
          w_sr_nxt   = 1'b1;
          w_lfsr_nxt = LFSR_SEED;
        end else if (iso_control_sym_flag) begin
          // Every other K-code, legal or not, goes through in the clear but
          // still consumes one key byte.
          w_sym_nxt  = iso_symbols;
          w_ill_nxt  = !w_is_legal_k;
          w_lfsr_nxt = w_lfsr_adv;
        end else begin
          w_sym_nxt  = iso_symbols ^ w_key;
          w_lfsr_nxt = w_lfsr_adv;
        end
      end
    endcase
  end

  // Register the LFSR and all outputs. Reset drops the symbol presented in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr                 <= LFSR_SEED;
      r_scr_symbols          <= 8'h00;
      r_scr_control_sym_flag <= 1'b0;
      r_scr_vld              <= 1'b0;
      r_illegal_k            <= 1'b0;
      r_sr_seen              <= 1'b0;
    end else begin
      r_lfsr                 <= w_lfsr_nxt;
      r_scr_symbols          <= w_sym_nxt;
      r_scr_control_sym_flag <= w_flag_nxt;
      r_scr_vld              <= w_vld_nxt;
      r_illegal_k            <= w_ill_nxt;
      r_sr_seen              <= w_sr_nxt;
    end
  end

  assign scr_symbols          = r_scr_symbols;
  assign scr_control_sym_flag = r_scr_control_sym_flag;
  assign scr_vld              = r_scr_vld;
  assign illegal_k            = r_illegal_k;
  assign sr_seen              = r_sr_seen;

endmodule

// File: tb/tb_dp_lane_scrambler.sv
// Self-checking bench for dp_lane_scrambler: directed vector table plus randomized stream vs keystream model.
// Latency: each applied symbol is checked one clock later, 1 ns after the capturing edge.
// Backpressure: none; the bench drives a new symbol every clock.
module tb_dp_lane_scrambler;

  logic       clk = 1'b0;
  logic       rst;
  logic       lane_en;
  logic       scramble_bypass;
  logic [7:0] iso_symbols;
  logic       iso_control_sym_flag;
  logic [7:0] scr_symbols;
  logic       scr_control_sym_flag;
  logic       scr_vld;
  logic       illegal_k;
  logic       sr_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_lane_scrambler dut (
    .clk                  (clk),
    .rst                  (rst),
    .lane_en              (lane_en),
    .scramble_bypass      (scramble_bypass),
    .iso_symbols          (iso_symbols),
    .iso_control_sym_flag (iso_control_sym_flag),
    .scr_symbols          (scr_symbols),
    .scr_control_sym_flag (scr_control_sym_flag),
    .scr_vld              (scr_vld),
    .illegal_k            (illegal_k),
    .sr_seen              (sr_seen)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       byp;
    logic       k;
    logic [7:0] sym;
    logic [7:0] e_sym;
    logic       e_k;
    logic       e_vld;
    logic       e_ill;
    logic       e_sr;
  } vec_t;

  vec_t vecs[$];

  // Keystream bytes counted from the seed: ks[n] is the key for the n-th
  // scrambler-consuming symbol after a re-seed.
  logic [7:0] ks [4096];
  logic [7:0] legal_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                  8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] exp_zero_run [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                                    8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

  function automatic logic is_legal(input logic [7:0] b);
    // K28.x has 11100 in the low five bits; plus K23.7, K27.7, K29.7, K30.7.
    return (b[4:0] == 5'h1C) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  task automatic build_keystream();
    logic [15:0] s;
    logic [7:0]  b;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 4096; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        fb   = s[15];
        b[j] = fb;
        s    = (s << 1) ^ (fb ? 16'h0039 : 16'h0000);
      end
      ks[i] = b;
    end
  endtask

  task automatic add(input logic r, input logic en, input logic byp, input logic k,
                     input logic [7:0] sym, input logic [7:0] e_sym, input logic e_k,
                     input logic e_vld, input logic e_ill, input logic e_sr);
    vec_t v;
    v.rst = r; v.en = en; v.byp = byp; v.k = k; v.sym = sym;
    v.e_sym = e_sym; v.e_k = e_k; v.e_vld = e_vld; v.e_ill = e_ill; v.e_sr = e_sr;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic en, input logic byp, input logic k,
                       input logic [7:0] sym);
    rst                  = r;
    lane_en              = en;
    scramble_bypass      = byp;
    iso_control_sym_flag = k;
    iso_symbols          = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int idx, input logic [7:0] e_sym,
                           input logic e_k, input logic e_vld, input logic e_ill, input logic e_sr);
    checks++;
    if ({scr_symbols, scr_control_sym_flag, scr_vld, illegal_k, sr_seen} !==
        {e_sym, e_k, e_vld, e_ill, e_sr}) begin
      errors++;
      $display("FAIL %s #%0d: got sym=%h k=%b vld=%b ill=%b sr=%b, want sym=%h k=%b vld=%b ill=%b sr=%b",
               name, idx, scr_symbols, scr_control_sym_flag, scr_vld, illegal_k, sr_seen,
               e_sym, e_k, e_vld, e_ill, e_sr);
    end
  endtask

  initial begin
    int         pos;
    logic       r_rst, r_en, r_byp, r_k;
    logic [7:0] r_sym, e_sym;
    logic       e_k, e_vld, e_ill, e_sr;
    int         sel;

    rst = 1'b1; lane_en = 1'b0; scramble_bypass = 1'b0;
    iso_control_sym_flag = 1'b0; iso_symbols = 8'h00;
    build_keystream();

    // Reset state, including a symbol presented during reset being dropped.
    add(1, 1, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 1, 8'h1C, 8'h00, 0, 0, 0, 0);
    // SR then sixteen zero data bytes give the raw keystream.
    add(0, 1, 0, 1, 8'h1C, 8'h1C, 1, 1, 0, 1);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'h00, exp_zero_run[i], 0, 1, 0, 0);
    // A BS in the middle consumes a key byte.
    add(0, 1, 0, 1, 8'h1C, 8'h1C, 1, 1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 8'hFF, 0, 1, 0, 0);
    add(0, 1, 0, 1, 8'hBC, 8'hBC, 1, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hC0, 0, 1, 0, 0);
    // Bypass passes data in the clear; dropping it restarts from the seed.
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 8'h4A, 8'h4A, 0, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hFF, 0, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h17, 0, 1, 0, 0);
    // Illegal K-code: in the clear, one pulse, LFSR still advances.
    add(0, 1, 0, 1, 8'h1C, 8'h1C, 1, 1, 0, 1);
    add(0, 1, 0, 1, 8'h55, 8'h55, 1, 1, 1, 0);
    add(0, 1, 0, 0, 8'h00, 8'h17, 0, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hC0, 0, 1, 0, 0);
    // Reset mid-stream after five data symbols.
    add(0, 1, 0, 1, 8'h1C, 8'h1C, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 8'h00, exp_zero_run[i], 0, 1, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hFF, 0, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h17, 0, 1, 0, 0);
    // Lane disable mid-stream, then re-enable from the seed.
    add(0, 1, 0, 0, 8'h00, 8'hC0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'hBC, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hFF, 0, 1, 0, 0);
    // Legal non-SR K-code (K27.7) advances the LFSR without flagging.
    add(0, 1, 0, 1, 8'hFB, 8'hFB, 1, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'hC0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].byp, vecs[i].k, vecs[i].sym);
      check_out("table", i, vecs[i].e_sym, vecs[i].e_k, vecs[i].e_vld, vecs[i].e_ill, vecs[i].e_sr);
    end

    // Randomized stream against the keystream-position model.
    apply(1, 1, 0, 0, 8'h00);
    pos   = 0;
    r_en  = 1'b1;
    r_byp = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) r_en = ~r_en;
      if ($urandom_range(0, 99) < 3) r_byp = ~r_byp;
      r_rst = ($urandom_range(0, 199) == 0);
      r_k   = ($urandom_range(0, 99) < 15);
      r_sym = 8'($urandom);
      if (r_k) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 3) r_sym = 8'h1C;
        else if (sel < 7) r_sym = legal_list[$urandom_range(0, 11)];
      end
      if (pos >= 4000) begin
        r_k   = 1'b1;
        r_sym = 8'h1C;
      end

      e_sym = 8'h00; e_k = 1'b0; e_vld = 1'b0; e_ill = 1'b0; e_sr = 1'b0;
      if (r_rst || !r_en) begin
        pos = 0;
      end else if (r_byp) begin
        e_sym = r_sym; e_k = r_k; e_vld = 1'b1; e_ill = r_k && !is_legal(r_sym);
        pos = 0;
      end else if (r_k && r_sym == 8'h1C) begin
        e_sym = r_sym; e_k = 1'b1; e_vld = 1'b1; e_sr = 1'b1;
        pos = 0;
      end else if (r_k) begin
        e_sym = r_sym; e_k = 1'b1; e_vld = 1'b1; e_ill = !is_legal(r_sym);
        pos++;
      end else begin
        e_sym = r_sym ^ ks[pos]; e_vld = 1'b1;
        pos++;
      end

      apply(r_rst, r_en, r_byp, r_k, r_sym);
      check_out("random", n, e_sym, e_k, e_vld, e_ill, e_sr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
